// File: rtl/stack_ctrl.sv
// Sequencer for the N-deep 16-bit data stack: one command at a time, depth tracking, sticky errors.
// Optional MUL opcode (13) is enabled by defining STACK_CTRL_MUL_EN; otherwise opcode 13 is illegal.
module stack_ctrl #(
    parameter int N  = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [15:0]   cmd_imm,
    input  logic [15:0]   qtop,
    input  logic [15:0]   qnext,
    output logic          stk_load,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [15:0]   stk_d,
    output logic [DW-1:0] depth,
    output logic          empty,
    output logic          full,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {IDLE, EXEC, SWAP2} state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_PUSHI  = 4'd1;
    localparam logic [3:0] OP_DROP   = 4'd2;
    localparam logic [3:0] OP_DUP    = 4'd3;
    localparam logic [3:0] OP_SWAP   = 4'd4;
    localparam logic [3:0] OP_OVER   = 4'd5;
    localparam logic [3:0] OP_ADD    = 4'd6;
    localparam logic [3:0] OP_SUB    = 4'd7;
    localparam logic [3:0] OP_AND    = 4'd8;
    localparam logic [3:0] OP_OR     = 4'd9;
    localparam logic [3:0] OP_XOR    = 4'd10;
    localparam logic [3:0] OP_NOT    = 4'd11;
    localparam logic [3:0] OP_CLRERR = 4'd12;
`ifdef STACK_CTRL_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'd13;
`endif

    localparam logic [DW-1:0] DEPTH_MAX = DW'(N);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    typedef struct packed {
        logic        legal;
        logic [1:0]  need;
        logic        grow;
        logic        inc;
        logic        dec;
        logic        load;
        logic        push;
        logic        pop;
        logic        swap;
        logic        clr;
        logic [15:0] d;
    } dec_t;

    state_t      state;
    dec_t        dc;
    logic        under, over, bad;
    logic [1:0]  ecode;
    logic [15:0] tmp;
    logic        x_inc, x_dec, x_err, x_clr, x_swap;
    logic [1:0]  x_code;

    assign cmd_ready = (state == IDLE);
    assign empty     = (depth == '0);
    assign full      = (depth == DEPTH_MAX);

    always_comb begin
        dc       = '0;
        dc.legal = 1'b1;
        case (cmd_op)
            OP_NOP:    ;
            OP_PUSHI:  begin dc.grow = 1'b1; dc.inc = 1'b1; dc.load = 1'b1; dc.push = 1'b1; dc.d = cmd_imm; end
            OP_DROP:   begin dc.need = 2'd1; dc.dec = 1'b1; dc.pop = 1'b1; end
            OP_DUP:    begin dc.need = 2'd1; dc.grow = 1'b1; dc.inc = 1'b1; dc.push = 1'b1; end
            // SWAP first collapses next out from under top (A,B,C -> A,C), then SWAP2 inserts B on top.
            OP_SWAP:   begin dc.need = 2'd2; dc.swap = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qtop; end
            OP_OVER:   begin dc.need = 2'd2; dc.grow = 1'b1; dc.inc = 1'b1; dc.load = 1'b1; dc.push = 1'b1; dc.d = qnext; end
            OP_ADD:    begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext + qtop; end
            OP_SUB:    begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext - qtop; end
            OP_AND:    begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext & qtop; end
            OP_OR:     begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext | qtop; end
            OP_XOR:    begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext ^ qtop; end
            OP_NOT:    begin dc.need = 2'd1; dc.load = 1'b1; dc.d = ~qtop; end
            OP_CLRERR: dc.clr = 1'b1;
`ifdef STACK_CTRL_MUL_EN
            OP_MUL:    begin dc.need = 2'd2; dc.dec = 1'b1; dc.load = 1'b1; dc.pop = 1'b1; dc.d = qnext * qtop; end
`endif
            default:   dc.legal = 1'b0;
        endcase
    end

    always_comb begin
        under = dc.legal && (depth < DW'(dc.need));
        over  = dc.legal && dc.grow && (depth >= DEPTH_MAX);
        bad   = !dc.legal || under || over;
        ecode = !dc.legal ? 2'd3 : (under ? 2'd1 : 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            depth    <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
            done     <= 1'b0;
            stk_load <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            stk_d    <= '0;
            tmp      <= '0;
            x_inc    <= 1'b0;
            x_dec    <= 1'b0;
            x_err    <= 1'b0;
            x_clr    <= 1'b0;
            x_swap   <= 1'b0;
            x_code   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        state    <= EXEC;
                        x_err    <= bad;
                        x_code   <= ecode;
                        x_clr    <= dc.clr;
                        x_swap   <= dc.swap & ~bad;
                        x_inc    <= dc.inc & ~bad;
                        x_dec    <= dc.dec & ~bad;
                        if (dc.swap) tmp <= qnext;
                        // A rejected command still occupies EXEC, but with every strobe held low.
                        stk_load <= dc.load & ~bad;
                        stk_push <= dc.push & ~bad;
                        stk_pop  <= dc.pop & ~bad;
                        stk_d    <= bad ? 16'h0 : dc.d;
                    end
                end
                EXEC: begin
                    if (x_inc)      depth <= depth + DEPTH_ONE;
                    else if (x_dec) depth <= depth - DEPTH_ONE;
                    if (x_clr) begin
                        err      <= 1'b0;
                        err_code <= 2'd0;
                    end else if (x_err) begin
                        err <= 1'b1;
                        if (err_code == 2'd0) err_code <= x_code;
                    end
                    if (x_swap) begin
                        state    <= SWAP2;
                        stk_load <= 1'b1;
                        stk_push <= 1'b1;
                        stk_pop  <= 1'b0;
                        stk_d    <= tmp;
                    end else begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        stk_load <= 1'b0;
                        stk_push <= 1'b0;
                        stk_pop  <= 1'b0;
                        stk_d    <= '0;
                    end
                end
                SWAP2: begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    stk_load <= 1'b0;
                    stk_push <= 1'b0;
                    stk_pop  <= 1'b0;
                    stk_d    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: emulated data stack, queue-based command model, per-cycle compare, random commands.
module tb_stack_ctrl;
    localparam int N  = 8;
    localparam int DW = 4;
`ifdef STACK_CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = 4'd0;
    logic [15:0]   cmd_imm = 16'h0;
    logic [15:0]   qtop, qnext;
    logic          stk_load, stk_push, stk_pop;
    logic [15:0]   stk_d;
    logic [DW-1:0] depth;
    logic          empty, full, done, err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    stack_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .qtop(qtop), .qnext(qnext),
        .stk_load(stk_load), .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d),
        .depth(depth), .empty(empty), .full(full), .done(done), .err(err), .err_code(err_code)
    );

    // Emulation of the attached data stack, reacting to the strobes.
    logic [N-1:0][15:0] s, ns;
    always_comb begin
        ns = s;
        if (stk_push && !stk_pop) for (int i = N - 1; i > 0; i--) ns[i] = s[i-1];
        if (stk_pop && !stk_push) begin
            for (int i = 0; i < N - 1; i++) ns[i] = s[i+1];
            ns[N-1] = 16'h0;
        end
        if (stk_load) ns[0] = stk_d;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) s <= '0;
        else        s <= ns;
    assign qtop  = s[0];
    assign qnext = s[1];

    // Reference model: stack contents as a queue (index 0 = top) plus error state.
    logic [15:0] q[$];
    bit          m_err;
    logic [1:0]  m_code;

    bit          e_ready, e_done, e_load, e_push, e_pop, chk_q;
    logic [15:0] e_d;
    int          checks = 0, failures = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, e_ready);
        chk("done", done, e_done);
        chk("stk_load", stk_load, e_load);
        chk("stk_push", stk_push, e_push);
        chk("stk_pop", stk_pop, e_pop);
        chk("stk_d", stk_d, e_d);
        chk("depth", depth, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == N);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        if (chk_q && q.size() > 0) chk("qtop", qtop, q[0]);
        if (chk_q && q.size() > 1) chk("qnext", qnext, q[1]);
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_on();
        reset = 1'b0;
        cmd_valid = 1'b0;
        q.delete();
        m_err = 1'b0; m_code = 2'd0;
        e_ready = 1'b1; e_done = 1'b0; chk_q = 1'b1;
        e_load = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_d = 16'h0;
    endtask

    // Decide from the rules what a command should do given the current model contents.
    function automatic void plan(input logic [3:0] op, input logic [15:0] imm, output bit ok,
                                 output logic [1:0] code, output bit l, output bit pu,
                                 output bit po, output logic [15:0] d);
        int sz = q.size();
        logic [15:0] a = (sz > 0) ? q[0] : 16'h0;
        logic [15:0] b = (sz > 1) ? q[1] : 16'h0;
        int need = 0;
        bit grows = 0, known = 1;
        l = 0; pu = 0; po = 0; d = 16'h0;
        case (op)
            4'd0:  ;
            4'd1:  begin grows = 1; l = 1; pu = 1; d = imm; end
            4'd2:  begin need = 1; po = 1; end
            4'd3:  begin need = 1; grows = 1; pu = 1; end
            4'd4:  begin need = 2; l = 1; po = 1; d = a; end
            4'd5:  begin need = 2; grows = 1; l = 1; pu = 1; d = b; end
            4'd6:  begin need = 2; l = 1; po = 1; d = b + a; end
            4'd7:  begin need = 2; l = 1; po = 1; d = b - a; end
            4'd8:  begin need = 2; l = 1; po = 1; d = b & a; end
            4'd9:  begin need = 2; l = 1; po = 1; d = b | a; end
            4'd10: begin need = 2; l = 1; po = 1; d = b ^ a; end
            4'd11: begin need = 1; l = 1; d = ~a; end
            4'd12: ;
            4'd13: begin
                if (MUL_EN) begin need = 2; l = 1; po = 1; d = 16'(b * a); end
                else known = 0;
            end
            default: known = 0;
        endcase
        ok   = known && (sz >= need) && !(grows && sz >= N);
        code = !known ? 2'd3 : ((sz < need) ? 2'd1 : 2'd2);
        if (!ok) begin l = 0; pu = 0; po = 0; d = 16'h0; end
    endfunction

    task automatic apply(input logic [3:0] op, input logic [15:0] imm, input bit ok, input logic [1:0] code);
        logic [15:0] a, b, r;
        a = (q.size() > 0) ? q[0] : 16'h0;
        b = (q.size() > 1) ? q[1] : 16'h0;
        if (!ok) begin
            m_err = 1'b1;
            if (m_code == 2'd0) m_code = code;
            return;
        end
        case (op)
            4'd1:  q.push_front(imm);
            4'd2:  void'(q.pop_front());
            4'd3:  q.push_front(a);
            4'd4:  begin q[0] = b; q[1] = a; end
            4'd5:  q.push_front(b);
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13: begin
                case (op)
                    4'd6:    r = b + a;
                    4'd7:    r = b - a;
                    4'd8:    r = b & a;
                    4'd9:    r = b | a;
                    4'd10:   r = b ^ a;
                    default: r = 16'(b * a);
                endcase
                void'(q.pop_front());
                q[0] = r;
            end
            4'd11: q[0] = ~a;
            4'd12: begin m_err = 1'b0; m_code = 2'd0; end
            default: ;
        endcase
    endtask

    // Issue one command from IDLE and walk its timeline; returns in the done cycle.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] imm, input bit abort = 1'b0);
        bit ok, l, pu, po;
        logic [1:0] code;
        logic [15:0] d, b_old;
        plan(op, imm, ok, code, l, pu, po, d);
        b_old = (q.size() > 1) ? q[1] : 16'h0;
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        step();
        cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 4'($urandom); cmd_imm = 16'($urandom);
        e_ready = 1'b0; e_done = 1'b0; chk_q = 1'b0;
        e_load = l; e_push = pu; e_pop = po; e_d = d;
        step();
        apply(op, imm, ok, code);
        if (ok && op == 4'd4) begin
            e_load = 1'b1; e_push = 1'b1; e_pop = 1'b0; e_d = b_old;
            if (abort) begin
                #2;
                rst_on();
                step();
                step();
                reset = 1'b1;
                step();
                return;
            end
            step();
        end
        e_ready = 1'b1; e_done = 1'b1; chk_q = 1'b1;
        e_load = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_d = 16'h0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            e_done = 1'b0;
        end
    endtask

    initial begin
        rst_on();
        repeat (3) step();
        reset = 1'b1;
        idle(1);

        // 1: 5 + 3
        done_cnt = 0;
        do_cmd(4'd1, 16'h0005);
        do_cmd(4'd1, 16'h0003);
        do_cmd(4'd6, 16'h0);
        idle(1);
        chk("t1_done_count", done_cnt, 3);
        chk("t1_qtop", qtop, 16'h0008);
        chk("t1_model_top", q[0], 16'h0008);
        chk("t1_depth", depth, 1);
        chk("t1_err", err, 0);

        // 2: swap
        do_cmd(4'd2, 16'h0);
        do_cmd(4'd1, 16'h2222);
        do_cmd(4'd1, 16'h1111);
        do_cmd(4'd4, 16'h0);
        chk("t2_qtop", qtop, 16'h2222);
        chk("t2_qnext", qnext, 16'h1111);
        chk("t2_depth", depth, 2);

        // 3: underflow then clear
        do_cmd(4'd2, 16'h0);
        do_cmd(4'd2, 16'h0);
        do_cmd(4'd1, 16'h0001);
        do_cmd(4'd7, 16'h0);
        chk("t3_err", err, 1);
        chk("t3_err_code", err_code, 1);
        chk("t3_model_code", m_code, 1);
        chk("t3_qtop", qtop, 16'h0001);
        do_cmd(4'd12, 16'h0);
        chk("t3_clr_err", err, 0);
        chk("t3_clr_code", err_code, 0);

        // 4: fill, overflow, drain
        do_cmd(4'd2, 16'h0);
        for (int k = 0; k < N; k++) do_cmd(4'd1, 16'(k + 16'h0100));
        chk("t4_full", full, 1);
        do_cmd(4'd3, 16'h0);
        chk("t4_err_code", err_code, 2);
        chk("t4_depth", depth, N);
        for (int k = 0; k < N; k++) do_cmd(4'd2, 16'h0);
        chk("t4_empty", empty, 1);
        do_cmd(4'd12, 16'h0);

        // 5: illegal opcode, then MUL (or illegal 13)
        do_cmd(4'd14, 16'h0);
        chk("t5_illegal", err_code, 3);
        do_cmd(4'd12, 16'h0);
        do_cmd(4'd1, 16'h0300);
        do_cmd(4'd1, 16'h0100);
        do_cmd(4'd13, 16'h0);
        chk("t5_mul_top", qtop, MUL_EN ? 16'h0000 : 16'h0100);
        chk("t5_mul_depth", depth, MUL_EN ? 1 : 2);
        chk("t5_mul_code", err_code, MUL_EN ? 0 : 3);
        do_cmd(4'd12, 16'h0);
        while (q.size() > 0) do_cmd(4'd2, 16'h0);

        // 6: reset during SWAP2
        do_cmd(4'd15, 16'h0);
        do_cmd(4'd1, 16'h1111);
        do_cmd(4'd1, 16'h2222);
        do_cmd(4'd4, 16'h0, 1'b1);
        chk("t6_depth", depth, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_err", err, 0);
        chk("t6_strobes", {stk_load, stk_push, stk_pop}, 3'b000);

        // randomized command stream
        repeat (400) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (q.size() < 3 && $urandom_range(0, 2) == 0) op = 4'd1;
            if ($urandom_range(0, 9) == 0) op = 4'd12;
            do_cmd(op, 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
